// File: rtl/store_unit.sv
// MEM-stage store path: lane formatting, misalignment check,
// and a small store buffer draining to data memory.
module store_unit #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        st_valid,
  input  logic [1:0]  st_type,
  input  logic [31:0] st_addr,
  input  logic [31:0] st_wdata,
  output logic        st_ready,
  output logic        st_exc,
  input  logic [31:0] ld_addr,
  output logic        ld_hit,
  output logic        sb_empty,
  output logic        m_wvalid,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  output logic [3:0]  m_byteen,
  input  logic        m_wready
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef struct packed {
    logic [29:0] wa;
    logic [31:0] data;
    logic [3:0]  be;
  } sb_ent_t;

  sb_ent_t          mem [DEPTH];
  logic [DEPTH-1:0] vld;
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic [CW-1:0]    count;

  logic    is_sw;
  logic    is_sh;
  logic    is_sb;
  logic    is_rsv;
  logic    misal;
  sb_ent_t fmt;
  sb_ent_t head;
  logic    push;
  logic    pop;
  logic    ld_unused;

  assign is_sw  = (st_type == 2'b00);
  assign is_sh  = (st_type == 2'b01);
  assign is_sb  = (st_type == 2'b10);
  assign is_rsv = (st_type == 2'b11);

  always_comb begin
    fmt    = '0;
    misal  = 1'b0;
    fmt.wa = st_addr[31:2];
    unique case (1'b1)
      is_sw: begin
        fmt.be   = 4'b1111;
        fmt.data = st_wdata;
        misal    = (st_addr[1:0] != 2'b00);
      end
      is_sh: begin
        fmt.be   = st_addr[1] ? 4'b1100 : 4'b0011;
        fmt.data = {2{st_wdata[15:0]}};
        misal    = st_addr[0];
      end
      is_sb: begin
        fmt.be   = 4'b0001 << st_addr[1:0];
        fmt.data = {4{st_wdata[7:0]}};
      end
      is_rsv: misal = 1'b1;
      default: misal = 1'b1;
    endcase
  end

  assign st_exc   = st_valid & misal;
  assign st_ready = (count < FULL);
  assign m_wvalid = (count != '0);
  assign sb_empty = (count == '0);
  assign push     = st_valid & st_ready & ~st_exc;
  assign pop      = m_wvalid & m_wready;

  assign head     = mem[rd_ptr];
  assign m_addr   = m_wvalid ? {head.wa, 2'b00} : '0;
  assign m_wdata  = m_wvalid ? head.data : '0;
  assign m_byteen = m_wvalid ? head.be : '0;

  // Word granularity: byte offset of the load is irrelevant.
  assign ld_unused = ^ld_addr[1:0];

  always_comb begin
    ld_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (vld[i] && mem[i].wa == ld_addr[31:2])
        ld_hit = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      vld    <= '0;
    end else begin
      if (pop) begin
        vld[rd_ptr] <= 1'b0;
        rd_ptr      <= rd_ptr + PW'(1);
      end
      if (push) begin
        mem[wr_ptr] <= fmt;
        vld[wr_ptr] <= 1'b1;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_store_unit.sv
// Scoreboard bench for store_unit: directed cases from the
// plan plus randomized traffic against a queue model.
module tb_store_unit;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        st_valid = 1'b0;
  logic [1:0]  st_type = 2'b00;
  logic [31:0] st_addr = '0;
  logic [31:0] st_wdata = '0;
  logic        st_ready;
  logic        st_exc;
  logic [31:0] ld_addr = '0;
  logic        ld_hit;
  logic        sb_empty;
  logic        m_wvalid;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [3:0]  m_byteen;
  logic        m_wready = 1'b0;

  store_unit #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .st_valid(st_valid), .st_type(st_type),
    .st_addr(st_addr), .st_wdata(st_wdata),
    .st_ready(st_ready), .st_exc(st_exc),
    .ld_addr(ld_addr), .ld_hit(ld_hit),
    .sb_empty(sb_empty), .m_wvalid(m_wvalid),
    .m_addr(m_addr), .m_wdata(m_wdata),
    .m_byteen(m_byteen), .m_wready(m_wready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  function automatic void chk(string name, logic [31:0] act,
                              logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endfunction

  // Reference formatting: plain arithmetic on the store rules.
  function automatic exp_t fmt_model(logic [1:0] t, logic [31:0] a,
                                     logic [31:0] d);
    exp_t e;
    int   off;
    off    = int'(a % 4);
    e.addr = a - 32'(off);
    if (t == 2'd0) begin
      e.data = d;
      e.be   = 4'hF;
    end else if (t == 2'd1) begin
      e.data = 32'(d[15:0]) * 32'h0001_0001;
      e.be   = (off >= 2) ? 4'hC : 4'h3;
    end else begin
      e.data = 32'(d[7:0]) * 32'h0101_0101;
      e.be   = 4'(1 << off);
    end
    return e;
  endfunction

  function automatic bit exc_model(bit v, logic [1:0] t,
                                   logic [31:0] a);
    if (!v) return 1'b0;
    if (t == 2'd3) return 1'b1;
    if (t == 2'd0) return (a % 4) != 0;
    if (t == 2'd1) return (a % 2) != 0;
    return 1'b0;
  endfunction

  function automatic bit hit_model(logic [31:0] la);
    foreach (exp_q[i])
      if (exp_q[i].addr / 4 == la / 4) return 1'b1;
    return 1'b0;
  endfunction

  // Monitor: compares every output against the model each cycle
  // and retires the head on a memory handshake.
  initial begin : monitor
    bit pop_now;
    @(posedge clk);
    forever begin
      @(negedge clk);
      #1;
      pop_now = 1'b0;
      chk("st_ready", st_ready, exp_q.size() < DEPTH);
      chk("sb_empty", sb_empty, exp_q.size() == 0);
      chk("m_wvalid", m_wvalid, exp_q.size() != 0);
      chk("ld_hit", ld_hit, hit_model(ld_addr));
      if (exp_q.size() != 0) begin
        chk("m_addr", m_addr, exp_q[0].addr);
        chk("m_wdata", m_wdata, exp_q[0].data);
        chk("m_byteen", m_byteen, exp_q[0].be);
        pop_now = m_wready;
      end else begin
        chk("m_addr_idle", m_addr, 32'h0);
        chk("m_wdata_idle", m_wdata, 32'h0);
        chk("m_byteen_idle", m_byteen, 32'h0);
      end
      @(posedge clk);
      if (!reset && pop_now) void'(exp_q.pop_front());
    end
  end

  task automatic step(input bit v, input logic [1:0] t,
                      input logic [31:0] a, input logic [31:0] d,
                      input bit wr, input logic [31:0] la,
                      input bit rst, output bit acc,
                      output bit exc);
    @(negedge clk);
    reset    = rst;
    st_valid = v;
    st_type  = t;
    st_addr  = a;
    st_wdata = d;
    m_wready = wr;
    ld_addr  = la;
    #1;
    exc = exc_model(v, t, a);
    chk("st_exc", st_exc, exc);
    acc = v && !exc && !rst && exp_q.size() < DEPTH;
    @(posedge clk);
    if (rst) exp_q.delete();
    else if (acc) exp_q.push_back(fmt_model(t, a, d));
  endtask

  task automatic idle(input bit wr, input logic [31:0] la);
    bit a, e;
    step(0, 2'd0, 32'h0, 32'h0, wr, la, 0, a, e);
  endtask

  initial begin : stim
    bit acc, exc;
    logic [1:0]  t;
    logic [31:0] a, d, la;
    logic [31:0] bases [4];
    bases = '{32'h4000, 32'h4004, 32'h5000, 32'h8000};

    step(0, 0, 0, 0, 0, 0, 1, acc, exc);
    step(0, 0, 0, 0, 0, 0, 1, acc, exc);
    idle(0, 0);
    #2;
    chk("rst_wvalid", m_wvalid, 0);
    chk("rst_empty", sb_empty, 1);
    chk("rst_ready", st_ready, 1);

    step(1, 2'd2, 32'h1003, 32'h1234_56AB, 0, 0, 0, acc, exc);
    #2;
    chk("sb_addr", m_addr, 32'h0000_1000);
    chk("sb_data", m_wdata, 32'hABAB_ABAB);
    chk("sb_be", m_byteen, 32'h8);
    idle(1, 0);
    step(1, 2'd1, 32'h2002, 32'hFFFF_BEEF, 0, 0, 0, acc, exc);
    #2;
    chk("sh_data", m_wdata, 32'hBEEF_BEEF);
    chk("sh_be", m_byteen, 32'hC);
    idle(1, 0);

    step(1, 2'd0, 32'h6, 32'h55, 0, 0, 0, acc, exc);
    #2;
    chk("misal_empty", sb_empty, 1);
    chk("misal_wvalid", m_wvalid, 0);
    step(1, 2'd1, 32'h1, 32'h55, 0, 0, 0, acc, exc);
    step(1, 2'd3, 32'h8, 32'h55, 0, 0, 0, acc, exc);
    chk("rsv_exc", exc, 1);

    step(1, 2'd0, 32'h10, 32'hA1, 0, 0, 0, acc, exc);
    step(1, 2'd0, 32'h20, 32'hA2, 0, 0, 0, acc, exc);
    #2;
    chk("full_ready", st_ready, 0);
    step(1, 2'd0, 32'h30, 32'hA3, 0, 0, 0, acc, exc);
    chk("held_acc", acc, 0);
    step(1, 2'd0, 32'h30, 32'hA3, 1, 0, 0, acc, exc);
    chk("nobypass_acc", acc, 0);
    step(1, 2'd0, 32'h30, 32'hA3, 1, 0, 0, acc, exc);
    chk("third_acc", acc, 1);
    repeat (3) idle(1, 0);

    step(1, 2'd2, 32'h4001, 32'h77, 0, 32'h4002, 0, acc, exc);
    #2;
    chk("hz_hit", ld_hit, 1);
    idle(0, 32'h4004);
    #2;
    chk("hz_miss", ld_hit, 0);
    idle(1, 32'h4002);
    #2;
    chk("hz_popped", ld_hit, 0);

    step(1, 2'd0, 32'h100, 32'hC0, 0, 0, 0, acc, exc);
    for (int i = 0; i < 8; i++) begin
      step(1, 2'd0, 32'h104 + 32'(4 * i), 32'hC1 + 32'(i),
           1, 0, 0, acc, exc);
      chk("simul_acc", acc, 1);
    end
    repeat (2) idle(1, 0);

    step(1, 2'd0, 32'h200, 32'hD0, 0, 0, 0, acc, exc);
    step(1, 2'd0, 32'h204, 32'hD1, 0, 0, 0, acc, exc);
    step(0, 0, 0, 0, 1, 0, 1, acc, exc);
    #2;
    chk("mid_wvalid", m_wvalid, 0);
    chk("mid_empty", sb_empty, 1);
    chk("mid_ready", st_ready, 1);
    step(1, 2'd0, 32'h300, 32'hE0, 0, 0, 0, acc, exc);
    #2;
    chk("post_rst_addr", m_addr, 32'h300);
    idle(1, 0);

    acc = 1'b1;
    exc = 1'b0;
    t = 0; a = 0; d = 0;
    for (int i = 0; i < 400; i++) begin
      bit v, wr;
      if (acc || exc || !st_valid) begin
        v = ($urandom_range(0, 3) != 0);
        t = 2'($urandom_range(0, 3));
        a = bases[$urandom_range(0, 3)] + 32'($urandom_range(0, 3));
        d = $urandom;
      end else begin
        v = 1'b1;
      end
      wr = ($urandom_range(0, 2) != 0);
      la = bases[$urandom_range(0, 3)] + 32'($urandom_range(0, 3));
      step(v, t, a, d, wr, la, 0, acc, exc);
    end

    for (int i = 0; i < 8 && exp_q.size() != 0; i++) idle(1, 0);
    chk("drained", exp_q.size(), 0);
    idle(0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
